exc_ctrl: RTL and testbench

- Exception/interrupt controller on the other end of the main decoder's exception interface.
- Generates ExtIRQ toward the decoder from an external device request, and consumes the decoder's EStatus/ERet.
- Captures the exception link register (ELR) and syndrome (ESR), and drives PC redirection for exception entry and return.
- Sits beside the fetch PC mux in the single-cycle LEGv8 datapath.

---
 rtl/exc_pkg.sv | 16 +
 rtl/sync2.sv | 24 ++
 rtl/exc_ctrl.sv | 115 +++++++++++
 tb/tb_exc_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        TAKEN   = 2'b01,
        HANDLER = 2'b10
    } exc_state_e;

    localparam logic [3:0] ES_NONE   = 4'b0000;
    localparam logic [3:0] ES_EXTIRQ = 4'b0001;
    localparam logic [3:0] ES_BADOP  = 4'b0010;

    localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single-bit level signal; both flops clear on reset.
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: ExtIRQ generation, ELR/ESR capture, PC redirect.
// Define EXC_IRQ_SYNC_EN to pass irq_req through a 2-flop synchronizer.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned     N          = 64,
    parameter logic [N-1:0]    EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned     CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq_req,
    output logic             irq_ack,
    output logic             ExtIRQ,
    input  logic [3:0]       EStatus,
    input  logic             ERet,
    input  logic [N-1:0]     pc,
    output logic             exc_take,
    output logic             eret_take,
    output logic [N-1:0]     next_exc_pc,
    output logic [N-1:0]     ELR,
    output logic [3:0]       ESR,
    output logic             in_handler,
    output logic             double_fault,
    output logic [CNT_W-1:0] exc_count
);

    exc_state_e       state_q, state_d;
    logic [N-1:0]     elr_q, elr_d;
    logic [3:0]       esr_q, esr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             df_q, df_d;
    logic             irq_s;
    logic             exc_raised;

`ifdef EXC_IRQ_SYNC_EN
    sync2 u_irq_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (irq_req),
        .q_o    (irq_s)
    );
`else
    assign irq_s = irq_req;
`endif

    assign exc_raised = (EStatus != ES_NONE);

    // Combinational requests are gated by reset so every output reads 0 while held.
    always_comb begin
        ExtIRQ      = reset && irq_s && (state_q == IDLE);
        exc_take    = reset && exc_raised && (state_q == IDLE);
        eret_take   = reset && ERet && (state_q != IDLE);
        next_exc_pc = exc_take ? EXC_VECTOR : elr_q;
        irq_ack     = (state_q == TAKEN) && (esr_q == ES_EXTIRQ);
        in_handler  = (state_q != IDLE);
    end

    always_comb begin
        state_d = state_q;
        elr_d   = elr_q;
        esr_d   = esr_q;
        cnt_d   = cnt_q;
        df_d    = df_q;
        unique case (state_q)
            IDLE: begin
                if (exc_raised) begin
                    state_d = TAKEN;
                    elr_d   = pc;
                    esr_d   = EStatus;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            TAKEN: begin
                state_d = ERet ? IDLE : HANDLER;
                if (exc_raised) begin
                    df_d = 1'b1;
                end
            end
            HANDLER: begin
                if (ERet) begin
                    state_d = IDLE;
                end
                if (exc_raised) begin
                    df_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            elr_q   <= '0;
            esr_q   <= '0;
            cnt_q   <= '0;
            df_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            elr_q   <= elr_d;
            esr_q   <= esr_d;
            cnt_q   <= cnt_d;
            df_q    <= df_d;
        end
    end

    assign ELR          = elr_q;
    assign ESR          = esr_q;
    assign double_fault = df_q;
    assign exc_count    = cnt_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl; honours EXC_IRQ_SYNC_EN for irq latency.
module tb_exc_ctrl;

`ifdef EXC_IRQ_SYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic        clk;
    logic        reset;
    logic        irq_req;
    logic        irq_ack;
    logic        ExtIRQ;
    logic [3:0]  EStatus;
    logic        ERet;
    logic [63:0] pc;
    logic        exc_take;
    logic        eret_take;
    logic [63:0] next_exc_pc;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic        in_handler;
    logic        double_fault;
    logic [7:0]  exc_count;

    int n_chk;
    int n_bad;

    exc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .irq_req      (irq_req),
        .irq_ack      (irq_ack),
        .ExtIRQ       (ExtIRQ),
        .EStatus      (EStatus),
        .ERet         (ERet),
        .pc           (pc),
        .exc_take     (exc_take),
        .eret_take    (eret_take),
        .next_exc_pc  (next_exc_pc),
        .ELR          (ELR),
        .ESR          (ESR),
        .in_handler   (in_handler),
        .double_fault (double_fault),
        .exc_count    (exc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; irq_req = 1'b1; EStatus = 4'b0001; ERet = 1'b0; pc = 64'h40;
        #1;
        step(3);
        n_chk++;
        if ({ExtIRQ, exc_take, eret_take, irq_ack, in_handler, double_fault} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {ExtIRQ, exc_take, eret_take, irq_ack, in_handler, double_fault});
        end
        n_chk++;
        if ({ELR, ESR, exc_count, next_exc_pc} !== '0) begin
            n_bad++;
            $display("FAIL reset_regs got ELR=%h ESR=%h cnt=%0d npc=%h exp all 0",
                     ELR, ESR, exc_count, next_exc_pc);
        end
        EStatus = 4'b0000;
        reset = 1'b1;
        #1;
        if (SyncLat > 0) begin
            n_chk++;
            if (ExtIRQ !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_sync_early got=%b exp=0", ExtIRQ);
            end
            step(SyncLat);
        end
        n_chk++;
        if (ExtIRQ !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_extirq got=%b exp=1", ExtIRQ);
        end
        irq_req = 1'b0;
        step(SyncLat + 1);
    endtask

    task automatic test_irq_entry;
        irq_req = 1'b1; pc = 64'h40;
        #1;
        step(SyncLat);
        n_chk++;
        if (ExtIRQ !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_extirq got=%b exp=1", ExtIRQ);
        end
        EStatus = 4'b0001;
        #1;
        n_chk++;
        if (exc_take !== 1'b1 || next_exc_pc !== 64'hD8) begin
            n_bad++;
            $display("FAIL irq_take got take=%b npc=%h exp take=1 npc=d8", exc_take, next_exc_pc);
        end
        step(1);
        EStatus = 4'b0000;
        #1;
        n_chk++;
        if (ELR !== 64'h40 || ESR !== 4'b0001 || irq_ack !== 1'b1 || exc_count !== 8'd1) begin
            n_bad++;
            $display("FAIL irq_capture got ELR=%h ESR=%b ack=%b cnt=%0d exp 40 0001 1 1",
                     ELR, ESR, irq_ack, exc_count);
        end
        n_chk++;
        if (ExtIRQ !== 1'b0 || in_handler !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_taken_mask got ExtIRQ=%b inh=%b exp 0 1", ExtIRQ, in_handler);
        end
        irq_req = 1'b0;
        step(1);
        n_chk++;
        if (irq_ack !== 1'b0 || in_handler !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_ack_pulse got ack=%b inh=%b exp 0 1", irq_ack, in_handler);
        end
        step(3);
        ERet = 1'b1;
        #1;
        n_chk++;
        if (eret_take !== 1'b1 || next_exc_pc !== 64'h40) begin
            n_bad++;
            $display("FAIL irq_eret got take=%b npc=%h exp 1 40", eret_take, next_exc_pc);
        end
        step(1);
        ERet = 1'b0;
        #1;
        n_chk++;
        if (in_handler !== 1'b0 || ExtIRQ !== 1'b0 || ELR !== 64'h40) begin
            n_bad++;
            $display("FAIL irq_return got inh=%b ExtIRQ=%b ELR=%h exp 0 0 40",
                     in_handler, ExtIRQ, ELR);
        end
    endtask

    task automatic test_badop;
        EStatus = 4'b0010; pc = 64'h100;
        #1;
        n_chk++;
        if (exc_take !== 1'b1) begin
            n_bad++;
            $display("FAIL badop_take got=%b exp=1", exc_take);
        end
        step(1);
        EStatus = 4'b0000;
        #1;
        n_chk++;
        if (ELR !== 64'h100 || ESR !== 4'b0010 || irq_ack !== 1'b0 || exc_count !== 8'd2) begin
            n_bad++;
            $display("FAIL badop_capture got ELR=%h ESR=%b ack=%b cnt=%0d exp 100 0010 0 2",
                     ELR, ESR, irq_ack, exc_count);
        end
        step(1);
        ERet = 1'b1;
        #1;
        n_chk++;
        if (eret_take !== 1'b1 || irq_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL badop_eret got take=%b ack=%b exp 1 0", eret_take, irq_ack);
        end
        step(1);
        n_chk++;
        if (in_handler !== 1'b0 || eret_take !== 1'b0) begin
            n_bad++;
            $display("FAIL eret_idle got inh=%b take=%b exp 0 0", in_handler, eret_take);
        end
        step(1);
        ERet = 1'b0;
        #1;
        n_chk++;
        if (in_handler !== 1'b0 || ELR !== 64'h100) begin
            n_bad++;
            $display("FAIL eret_idle_hold got inh=%b ELR=%h exp 0 100", in_handler, ELR);
        end
    endtask

    task automatic test_nesting;
        EStatus = 4'b0010; pc = 64'h200;
        step(1);
        EStatus = 4'b0000;
        step(1);
        irq_req = 1'b1;
        #1;
        step(SyncLat);
        n_chk++;
        if (ExtIRQ !== 1'b0 || in_handler !== 1'b1) begin
            n_bad++;
            $display("FAIL nest_mask got ExtIRQ=%b inh=%b exp 0 1", ExtIRQ, in_handler);
        end
        EStatus = 4'b0010; pc = 64'h300;
        #1;
        n_chk++;
        if (exc_take !== 1'b0 || next_exc_pc !== 64'h200) begin
            n_bad++;
            $display("FAIL nest_no_take got take=%b npc=%h exp 0 200", exc_take, next_exc_pc);
        end
        step(1);
        EStatus = 4'b0000;
        #1;
        n_chk++;
        if (double_fault !== 1'b1 || ELR !== 64'h200 || ESR !== 4'b0010 || exc_count !== 8'd3)
        begin
            n_bad++;
            $display("FAIL nest_double got df=%b ELR=%h ESR=%b cnt=%0d exp 1 200 0010 3",
                     double_fault, ELR, ESR, exc_count);
        end
        ERet = 1'b1;
        #1;
        n_chk++;
        if (eret_take !== 1'b1 || ExtIRQ !== 1'b0) begin
            n_bad++;
            $display("FAIL nest_eret got take=%b ExtIRQ=%b exp 1 0", eret_take, ExtIRQ);
        end
        step(1);
        ERet = 1'b0;
        #1;
        n_chk++;
        if (ExtIRQ !== 1'b1 || in_handler !== 1'b0 || double_fault !== 1'b1) begin
            n_bad++;
            $display("FAIL nest_refire got ExtIRQ=%b inh=%b df=%b exp 1 0 1",
                     ExtIRQ, in_handler, double_fault);
        end
        irq_req = 1'b0;
        step(SyncLat + 1);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 260; i++) begin
            EStatus = 4'b0010; pc = 64'h1000 + 64'(i);
            step(1);
            EStatus = 4'b0000; ERet = 1'b1;
            step(1);
            ERet = 1'b0;
            #1;
            if (i == 99) begin
                n_chk++;
                if (exc_count !== 8'd103) begin
                    n_bad++;
                    $display("FAIL sat_mid got=%0d exp=103", exc_count);
                end
            end
        end
        n_chk++;
        if (exc_count !== 8'd255 || ELR !== 64'h1103) begin
            n_bad++;
            $display("FAIL sat_hold got cnt=%0d ELR=%h exp 255 1103", exc_count, ELR);
        end
    endtask

    task automatic test_mid_reset;
        EStatus = 4'b0001; pc = 64'h500;
        step(1);
        EStatus = 4'b0000;
        step(1);
        n_chk++;
        if (in_handler !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre got inh=%b exp 1", in_handler);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if (in_handler !== 1'b0 || exc_count !== 8'd0 || ELR !== 64'h0 || ESR !== 4'b0
            || double_fault !== 1'b0 || irq_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst got inh=%b cnt=%0d ELR=%h ESR=%b df=%b ack=%b exp all 0",
                     in_handler, exc_count, ELR, ESR, double_fault, irq_ack);
        end
        step(1);
        reset = 1'b1;
        step(1);
        n_chk++;
        if (in_handler !== 1'b0 || irq_ack !== 1'b0 || exc_count !== 8'd0) begin
            n_bad++;
            $display("FAIL midrst_after got inh=%b ack=%b cnt=%0d exp 0 0 0",
                     in_handler, irq_ack, exc_count);
        end
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        test_reset();
        test_irq_entry();
        test_badop();
        test_nesting();
        test_saturation();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
